mem_req_queue: RTL

Request buffer between the `cpu` and `memory` blocks inside `afu`. It accepts cache-line read/write requests from the CPU into a small FIFO and issues them to `memory` one at a time. It returns each response to the CPU in order and gates new requests on `buffer_addr_valid`. This decouples CPU request generation from memory/CCI-P latency.

---
 rtl/data_types.sv | 20 ++
 rtl/mem_req_fifo.sv | 52 +++++
 rtl/mem_req_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/data_types.sv
// Shared types and default widths for the CPU-to-memory request queue.
package data_types;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 512;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } t_mem_req;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } t_mem_req_queue_state;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO of request entries; extra pointer MSB tells full from empty.
module mem_req_fifo
    import data_types::*;
#(
    parameter type T     = t_mem_req,
    parameter int  DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IDX_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [IDX_W:0]   wr_ptr;
    logic [IDX_W:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[IDX_W-1:0]];

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_queue.sv
// Buffers CPU cache-line requests and issues them to memory one at a time, in order.
// Optional statistics ports are enabled by defining MEM_REQ_QUEUE_STATS_EN.
module mem_req_queue
    import data_types::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              buffer_addr_valid,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef MEM_REQ_QUEUE_STATS_EN
    ,
    output logic [31:0]              stat_rd_count,
    output logic [31:0]              stat_wr_count,
    output logic [$clog2(DEPTH):0]   stat_max_occupancy
`endif
);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } t_entry;

    t_mem_req_queue_state    state;
    t_mem_req_queue_state    next_state;
    t_entry                  push_entry;
    t_entry                  head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    pop;
    logic                    push;
    logic                    run;

    // Holds req_ready low through reset even if buffer_addr_valid is already high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign req_ready  = run && !fifo_full && buffer_addr_valid;
    assign push       = req_valid && req_ready;
    assign push_entry = '{write: req_write, addr: req_addr, data: req_data};

    mem_req_fifo #(
        .T     (t_entry),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state    = state;
        mem_req_valid = 1'b0;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    pop        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The head only moves on pop in WAIT, so these stay stable while ISSUE stalls.
    always_comb begin
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        if (state == ISSUE) begin
            mem_req_write = head.write;
            mem_req_addr  = head.addr;
            mem_req_data  = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= pop;
            if (pop) begin
                resp_write <= head.write;
                resp_data  <= head.write ? '0 : mem_resp_data;
            end
        end
    end

`ifdef MEM_REQ_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_count      <= '0;
            stat_wr_count      <= '0;
            stat_max_occupancy <= '0;
        end else begin
            if (pop && !head.write && (stat_rd_count != '1)) begin
                stat_rd_count <= stat_rd_count + 1'b1;
            end
            if (pop && head.write && (stat_wr_count != '1)) begin
                stat_wr_count <= stat_wr_count + 1'b1;
            end
            if (fifo_count > stat_max_occupancy) begin
                stat_max_occupancy <= fifo_count;
            end
        end
    end
`endif

    a_resp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n) mem_resp_valid |-> (state == WAIT)
    );

    a_count_in_range: assert property (
        @(posedge clk) disable iff (!rst_n) fifo_count <= ($clog2(DEPTH) + 1)'(DEPTH)
    );

endmodule
